add_share_arbiter: RTL and testbench
====================================

Name: add_share_arbiter

Overview:
Round-robin arbiter and sequencer that shares one two-operand serial adder (first/second-operand `p_seq` protocol, `res_valid`/`s` result) among NUM_REQ requesters. It latches the winning requester's operand pair and feeds them to the adder on consecutive cycles. It then waits for the adder result and returns it to that requester with a one-cycle done pulse. A timeout guards against an adder that never raises `res_valid`.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
DATA_W, 4, operand/result width; must match adder width
TIMEOUT_CYC, 8, max cycles spent in WAIT_RES before an error response (>=1)

Ports:
clk  input  1  clock; all logic on rising edge
rst  input  1  synchronous active-low reset
req  input  NUM_REQ  per-requester request level
op_a  input  NUM_REQ*DATA_W  flattened first operands; requester i at [i*DATA_W +: DATA_W]
op_b  input  NUM_REQ*DATA_W  flattened second operands, same packing
gnt  output  NUM_REQ  one-hot grant; high from SEND_P1 through RESP
done  output  NUM_REQ  one-hot, one-cycle completion pulse to granted requester
res  output  DATA_W  result; valid only while done is nonzero
err  output  1  high with done when the transaction timed out
add_p  output  DATA_W  operand to adder
add_p_seq  output  2  0 = none, 1 = first operand, 2 = second operand
add_res_valid  input  1  adder result valid (level or pulse accepted)
add_s  input  DATA_W  adder sum

Behaviour:
- Reset is synchronous, active-low, and checked before all other logic. While rst is 0 at a rising edge, the next state is:
  - state = IDLE.
  - gnt, done, res, err, add_p and add_p_seq = 0.
  - Timeout counter = 0.
  - Round-robin pointer last = NUM_REQ-1, so requester 0 has top priority first.
  - Reset mid-transaction abandons the operation; no done pulse is produced.
- FSM states and transitions:
  - IDLE: add_p_seq = 0. If any req bit is set, the winner is the first set bit searching last+1, last+2, … modulo NUM_REQ. On that edge:
    - Latch winner index, op_a and op_b slices.
    - Set last = winner.
    - Go to SEND_P1.
    - If no req bit is set, stay in IDLE.
  - SEND_P1 (one cycle): gnt[winner] = 1, add_p = latched a, add_p_seq = 1. Go to SEND_P2.
  - SEND_P2 (one cycle): add_p = latched b, add_p_seq = 2. Clear the timeout counter. Go to WAIT_RES.
  - WAIT_RES: add_p_seq = 0, add_p = 0.
    - If add_res_valid = 1: capture add_s into res, set err = 0, go to RESP.
    - Otherwise increment the counter. When the counter reaches TIMEOUT_CYC, set res = 0, err = 1, go to RESP.
  - RESP (one cycle): done[winner] = 1 with res/err driven. Go to IDLE. gnt drops on exit.
- add_res_valid is sampled only in WAIT_RES. A stale high level left over from the previous transaction is ignored in every other state.
- Latency with a 1-cycle adder: req seen in IDLE at cycle 0, SEND_P1 at cycle 1, SEND_P2 at cycle 2, WAIT_RES at cycle 3 (valid seen), RESP/done at cycle 4, back in IDLE at cycle 5. A slower adder adds one cycle per WAIT_RES cycle.
- Request rules:
  - Operands are latched only at grant; later changes to op_a/op_b or req have no effect on the current transaction.
  - Dropping req mid-transaction does not cancel it; done is still pulsed.
  - req still high in IDLE after done is a new request. The minimum inter-transaction gap is the single IDLE cycle.
- Arithmetic: modulo 2^DATA_W; the sum wraps and no carry is reported. res is add_s verbatim.
- Outputs other than res/err/done are zero in any state where they are not listed above.
- The default/illegal state code returns to IDLE with all outputs zero.

Test Plan:
1. Reset then req=0001, op_a[0]=2, op_b[0]=3, 1-cycle adder model -> add_p_seq sequence 1,2 with add_p 2,3 at cycles 1,2; done=0001, res=5, err=0 at cycle 4; gnt=0001 during cycles 1..4.
2. req=1111 held continuously, distinct operands -> grants in order 0,1,2,3,0 with exactly one IDLE cycle between RESP and the next SEND_P1; each done carries that requester's sum.
3. op_a=9, op_b=8 (DATA_W=4) -> res=1 (wrap), err=0.
4. Adder model never asserts res_valid, TIMEOUT_CYC=8 -> done after 8 WAIT_RES cycles, res=0, err=1; the next request completes normally.
5. Stale add_res_valid held high from the prior transaction -> not accepted in IDLE/SEND_P1/SEND_P2; the result is taken only in WAIT_RES.
6. rst driven low during WAIT_RES -> at the next edge all outputs are 0, no done pulse, state IDLE. After release, pending req=0110 grants requester 1 first (pointer reset).

Source files
------------

// File: rtl/add_share_arbiter_if.sv
// Requester-side and adder-side signal bundle for add_share_arbiter.
// The arbiter connects through the slave modport; the environment drives the master side.
interface add_share_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 4
);
  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ*DATA_W-1:0] op_a;
  logic [NUM_REQ*DATA_W-1:0] op_b;
  logic [NUM_REQ-1:0]        gnt;
  logic [NUM_REQ-1:0]        done;
  logic [DATA_W-1:0]         res;
  logic                      err;
  logic [DATA_W-1:0]         add_p;
  logic [1:0]                add_p_seq;
  logic                      add_res_valid;
  logic [DATA_W-1:0]         add_s;

  modport master (
    output req, op_a, op_b, add_res_valid, add_s,
    input  gnt, done, res, err, add_p, add_p_seq
  );

  modport slave (
    input  req, op_a, op_b, add_res_valid, add_s,
    output gnt, done, res, err, add_p, add_p_seq
  );
endinterface

// File: rtl/add_share_arbiter.sv
// Round-robin arbiter that shares one serial two-operand adder among NUM_REQ requesters,
// sequencing operands to the adder and returning the sum (or a timeout error) with a done pulse.
module add_share_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int DATA_W      = 4,
  parameter int TIMEOUT_CYC = 8
) (
  input logic                 clk,
  input logic                 rst,
  add_share_arbiter_if.slave  bus
);
  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [NUM_REQ-1:0] ONE_HOT0  = {{(NUM_REQ-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0]   CNT_LIMIT = CNT_W'(TIMEOUT_CYC);
  localparam logic [IDX_W-1:0]   LAST_RST  = IDX_W'(NUM_REQ - 1);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_SEND_P1  = 3'd1,
    S_SEND_P2  = 3'd2,
    S_WAIT_RES = 3'd3,
    S_RESP     = 3'd4
  } state_e;

  state_e             state_q;
  logic [IDX_W-1:0]   win_q;
  logic [IDX_W-1:0]   last_q;
  logic [DATA_W-1:0]  b_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [NUM_REQ-1:0] gnt_q;
  logic [NUM_REQ-1:0] done_q;
  logic [DATA_W-1:0]  res_q;
  logic               err_q;
  logic [DATA_W-1:0]  add_p_q;
  logic [1:0]         add_p_seq_q;

  logic               win_found_d;
  logic [IDX_W-1:0]   win_d;

  // Round-robin search starting just after the last winner
  always_comb begin
    win_found_d = 1'b0;
    win_d       = last_q;
    for (int k = 1; k <= NUM_REQ; k++) begin
      if (!win_found_d && bus.req[(int'(last_q) + k) % NUM_REQ]) begin
        win_found_d = 1'b1;
        win_d       = IDX_W'((int'(last_q) + k) % NUM_REQ);
      end else begin
        win_found_d = win_found_d;
      end
    end
  end

  // Transaction sequencer; every output is registered on the transition into its state
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      win_q       <= '0;
      last_q      <= LAST_RST;
      b_q         <= '0;
      cnt_q       <= '0;
      gnt_q       <= '0;
      done_q      <= '0;
      res_q       <= '0;
      err_q       <= 1'b0;
      add_p_q     <= '0;
      add_p_seq_q <= 2'd0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (win_found_d) begin
            win_q       <= win_d;
            last_q      <= win_d;
            b_q         <= bus.op_b[win_d*DATA_W +: DATA_W];
            gnt_q       <= ONE_HOT0 << win_d;
            add_p_q     <= bus.op_a[win_d*DATA_W +: DATA_W];
            add_p_seq_q <= 2'd1;
            state_q     <= S_SEND_P1;
          end else begin
            state_q     <= S_IDLE;
          end
        end
        S_SEND_P1: begin
          add_p_q     <= b_q;
          add_p_seq_q <= 2'd2;
          state_q     <= S_SEND_P2;
        end
        S_SEND_P2: begin
          add_p_q     <= '0;
          add_p_seq_q <= 2'd0;
          cnt_q       <= '0;
          state_q     <= S_WAIT_RES;
        end
        // Result is only looked at here, so a stale valid level elsewhere is ignored
        S_WAIT_RES: begin
          if (bus.add_res_valid) begin
            res_q   <= bus.add_s;
            err_q   <= 1'b0;
            done_q  <= ONE_HOT0 << win_q;
            state_q <= S_RESP;
          end else if (cnt_q + CNT_W'(1) == CNT_LIMIT) begin
            res_q   <= '0;
            err_q   <= 1'b1;
            done_q  <= ONE_HOT0 << win_q;
            state_q <= S_RESP;
          end else begin
            cnt_q   <= cnt_q + CNT_W'(1);
          end
        end
        S_RESP: begin
          gnt_q   <= '0;
          done_q  <= '0;
          res_q   <= '0;
          err_q   <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          gnt_q       <= '0;
          done_q      <= '0;
          res_q       <= '0;
          err_q       <= 1'b0;
          add_p_q     <= '0;
          add_p_seq_q <= 2'd0;
          cnt_q       <= '0;
          state_q     <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.done      = done_q;
  assign bus.res       = res_q;
  assign bus.err       = err_q;
  assign bus.add_p     = add_p_q;
  assign bus.add_p_seq = add_p_seq_q;
endmodule

// File: tb/tb_add_share_arbiter.sv
// Directed, table-driven bench for add_share_arbiter with a small serial-adder model.
module tb_add_share_arbiter;
  localparam int M_NORMAL = 0;
  localparam int M_NEVER  = 1;
  localparam int M_STALE  = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   total = 0;
  int   bad   = 0;

  add_share_arbiter_if #(.NUM_REQ(4), .DATA_W(4)) bus();

  add_share_arbiter #(.NUM_REQ(4), .DATA_W(4), .TIMEOUT_CYC(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Adder model: latches first operand, sums on second, raises valid dly cycles later
  int         mode = M_NORMAL;
  int         dly  = 0;
  logic [3:0] a_l   = 4'd0;
  logic [3:0] sum_q = 4'd0;
  logic       pend_q = 1'b0;
  int         dly_q  = 0;

  always @(posedge clk) begin
    if (bus.add_p_seq == 2'd1) a_l <= bus.add_p;
    if (bus.add_p_seq == 2'd2) begin
      sum_q  <= a_l + bus.add_p;
      dly_q  <= dly;
      pend_q <= 1'b1;
    end else if (pend_q) begin
      if (dly_q == 0) pend_q <= 1'b0;
      else            dly_q  <= dly_q - 1;
    end
  end

  assign bus.add_s         = sum_q;
  assign bus.add_res_valid = (mode == M_STALE) ? 1'b1 :
                             (mode == M_NEVER) ? 1'b0 : (pend_q && dly_q == 0);

  typedef struct {
    logic [3:0]  req;
    logic [15:0] op_a;
    logic [15:0] op_b;
    int          mode;
    int          dly;
    int          win;
    logic [3:0]  exp_res;
    logic        exp_err;
    int          exp_wait;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic run_vec(input vec_t v);
    logic [3:0] ea, eb, eg;
    int n;
    ea = v.op_a[v.win*4 +: 4];
    eb = v.op_b[v.win*4 +: 4];
    eg = 4'b0001 << v.win;
    mode = v.mode;
    dly  = v.dly;
    @(negedge clk);
    bus.req  = v.req;
    bus.op_a = v.op_a;
    bus.op_b = v.op_b;
    @(negedge clk);
    chk("p1_gnt", bus.gnt, eg);
    chk("p1_seq", bus.add_p_seq, 2'd1);
    chk("p1_add_p", bus.add_p, ea);
    bus.req  = 4'b0000;
    bus.op_a = ~v.op_a;
    bus.op_b = ~v.op_b;
    @(negedge clk);
    chk("p2_gnt", bus.gnt, eg);
    chk("p2_seq", bus.add_p_seq, 2'd2);
    chk("p2_add_p", bus.add_p, eb);
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (bus.done == 4'b0000) chk("wait_gnt", bus.gnt, eg);
    end while (bus.done == 4'b0000 && n < 30);
    chk("wait_cycles", n - 1, v.exp_wait);
    chk("done", bus.done, eg);
    chk("resp_gnt", bus.gnt, eg);
    chk("res", bus.res, v.exp_res);
    chk("err", bus.err, v.exp_err);
    @(negedge clk);
    chk("idle_done", bus.done, 4'b0000);
    chk("idle_gnt", bus.gnt, 4'b0000);
  endtask

  initial begin
    logic [3:0] sums[4];
    logic [3:0] eg;
    int t, ph;
    int n;

    vecs[0] = '{4'b0001, 16'h0002, 16'h0003, M_NORMAL, 0, 0, 4'd5,  1'b0, 1};
    vecs[1] = '{4'b1111, 16'h4321, 16'h1111, M_NORMAL, 0, 1, 4'd3,  1'b0, 1};
    vecs[2] = '{4'b1001, 16'h9000, 16'h8000, M_NORMAL, 0, 3, 4'd1,  1'b0, 1};
    vecs[3] = '{4'b0100, 16'h0700, 16'h0600, M_NEVER,  0, 2, 4'd0,  1'b1, 8};
    vecs[4] = '{4'b0101, 16'h000F, 16'h000F, M_NORMAL, 0, 0, 4'd14, 1'b0, 1};
    vecs[5] = '{4'b0010, 16'h0050, 16'h00A0, M_NORMAL, 3, 1, 4'd15, 1'b0, 4};
    vecs[6] = '{4'b1100, 16'h0600, 16'h0400, M_STALE,  0, 2, 4'd10, 1'b0, 1};
    vecs[7] = '{4'b1011, 16'h3ABC, 16'h3DEF, M_NORMAL, 0, 3, 4'd6,  1'b0, 1};

    bus.req  = 4'b0000;
    bus.op_a = 16'h0000;
    bus.op_b = 16'h0000;

    do_reset();
    @(negedge clk);
    chk("rst_gnt", bus.gnt, 4'b0000);
    chk("rst_done", bus.done, 4'b0000);
    chk("rst_seq", bus.add_p_seq, 2'd0);
    chk("rst_add_p", bus.add_p, 4'd0);
    chk("rst_res", bus.res, 4'd0);
    chk("rst_err", bus.err, 1'b0);

    for (int i = 0; i < 8; i++) run_vec(vecs[i]);

    // All four requesting continuously: strict rotation with one IDLE cycle between
    do_reset();
    mode = M_NORMAL;
    dly  = 0;
    sums[0] = 4'h6; sums[1] = 4'hC; sums[2] = 4'h3; sums[3] = 4'h3;
    @(negedge clk);
    bus.req  = 4'b1111;
    bus.op_a = 16'h4321;
    bus.op_b = 16'hF0A5;
    for (int k = 1; k <= 25; k++) begin
      @(negedge clk);
      t  = (k - 1) / 5;
      ph = (k - 1) % 5;
      eg = (ph < 4) ? (4'b0001 << (t % 4)) : 4'b0000;
      chk("rr_gnt", bus.gnt, eg);
      if (ph == 3) begin
        chk("rr_done", bus.done, eg);
        chk("rr_res", bus.res, sums[t % 4]);
      end else begin
        chk("rr_nodone", bus.done, 4'b0000);
      end
      if (k == 22) bus.req = 4'b0000;
    end

    // Reset during WAIT_RES abandons the transaction and restores the pointer
    do_reset();
    mode = M_NEVER;
    @(negedge clk);
    bus.req  = 4'b0010;
    bus.op_a = 16'h0050;
    bus.op_b = 16'h00A0;
    @(negedge clk);
    bus.req = 4'b0000;
    repeat (2) @(negedge clk);
    chk("pre_rst_gnt", bus.gnt, 4'b0010);
    rst      = 1'b0;
    mode     = M_NORMAL;
    bus.req  = 4'b0110;
    bus.op_a = 16'h0210;
    bus.op_b = 16'h0530;
    @(negedge clk);
    chk("mid_rst_gnt", bus.gnt, 4'b0000);
    chk("mid_rst_done", bus.done, 4'b0000);
    chk("mid_rst_seq", bus.add_p_seq, 2'd0);
    chk("mid_rst_add_p", bus.add_p, 4'd0);
    chk("mid_rst_res", bus.res, 4'd0);
    chk("mid_rst_err", bus.err, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    chk("post_rst_gnt", bus.gnt, 4'b0010);
    chk("post_rst_seq", bus.add_p_seq, 2'd1);
    chk("post_rst_add_p", bus.add_p, 4'd1);
    bus.req = 4'b0000;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (bus.done == 4'b0000 && n < 20);
    chk("post_rst_done", bus.done, 4'b0010);
    chk("post_rst_res", bus.res, 4'd4);
    chk("post_rst_lat", n, 3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
